tlc_light_monitor: RTL
======================

Name: tlc_light_monitor

Overview:
- Receive-side checker for the four-approach traffic light controller outputs.
- Samples the four 3-bit lamp buses every clock and decodes them back into phase S1..S6.
- Tracks phase order and dwell length against the controller timing and raises a sticky fault code on any unsafe or out-of-spec behaviour.
- Sits beside the controller (or at the lamp-driver end) as a safety interlock and verification aid.

Parameters:
- TY, 7: S1/S5 terminal count; dwell = TY+1 cycles.
- TR, 2: S2/S6 terminal count; dwell = TR+1 cycles.
- TYY, 5: S3 terminal count; dwell = TYY+1 cycles.
- TRR, 3: S4 terminal count; dwell = TRR+1 cycles.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- L2R, in, 3: lamp code, L-to-R approach.
- D2R, in, 3: lamp code, D-to-R approach.
- L2D, in, 3: lamp code, L-to-D approach.
- R2LandR2D, in, 3: lamp code, shared R-to-L / R-to-D approach.
- clr, in, 1: clears a latched fault and returns to unlocked.
- phase, out, 3: decoded phase of last sample; 0..5 = S1..S6, 7 = illegal/unknown.
- dwell, out, 4: cycles spent in the current phase including this one; saturates at 15.
- locked, out, 1: monitor is synchronised to the sequence.
- fault, out, 1: sticky fault flag.
- fault_code, out, 3: 0 none, 1 encoding, 2 conflict, 3 sequence, 4 short, 5 overstay.
- cycle_done, out, 1: one-cycle pulse on a correct S6→S1 transition while locked.

Behaviour:
- Lamp codes: GREEN=001, YELLOW=010, RED=100. Any other value is an encoding error.
- Phase patterns, given as (L2R, R2LandR2D, L2D, D2R):
  - S1 = G,G,R,R
  - S2 = G,Y,R,R
  - S3 = G,R,G,R
  - S4 = Y,R,Y,R
  - S5 = R,R,R,G
  - S6 = R,R,R,Y
- A legal-coded pattern that matches no phase decodes to phase 7.
- Conflict: both lamps non-RED for the pair (R2LandR2D, L2D), or D2R non-RED together with any other lamp non-RED.
- Expected dwell, S1..S6: 8, 3, 6, 4, 8, 3 cycles. Full cycle = 32 cycles.
- All outputs are registered and update at the same edge that samples the inputs (1-cycle latency from lamp change to output).
- Reset: phase=7, dwell=0, locked=0, fault=0, fault_code=0, cycle_done=0, FSM=UNLOCKED. rst overrides clr and any in-progress check.
- FSM states:
  - UNLOCKED: track phase/dwell without timing checks. Any change to a different legal phase → TRACK, dwell=1. Dwell observed before the first transition is never judged.
  - TRACK: locked=1.
    - Same phase → dwell+1. If the new dwell exceeds expected → FAULT, code 5 (overstay).
    - Change to the expected successor (S6 wraps to S1) → if dwell ≠ expected → FAULT, code 4 (short); otherwise dwell=1. cycle_done=1 on S6→S1.
    - Change to any other legal phase → FAULT, code 3 (sequence).
  - FAULT: fault=1, locked=0, fault_code frozen, phase/dwell keep tracking. Exit only via rst, or via clr → UNLOCKED with fault_code=0.
- Encoding and conflict checks run in every state, including UNLOCKED. In FAULT they do not overwrite the frozen code.
- Priority when several faults apply in one sample: conflict > encoding > sequence > short/overstay.
- clr in the same cycle as a new fault: fault wins and is latched.
- Phase 7 without an encoding or conflict error while in TRACK → code 3 (sequence).

Decomposition:
- Package tlc_pkg holds:
  - lamp codes GREEN/YELLOW/RED
  - phase indices S1..S6 and PH_NONE=7
  - fault code constants
  - default TY/TR/TYY/TRR
  - dwell-length function expected_dwell(phase)
- One sub-module, tlc_pattern_decode: combinational mapping of the four lamp buses to phase index, enc_err and conflict flags. The FSM, dwell counter and fault latch stay in tlc_light_monitor.

Test Plan:
- Drive the controller's golden 32-cycle pattern for 3 cycles after rst → locked=1 after the first S1→S2 edge; fault=0 throughout; cycle_done pulses exactly every 32 cycles.
- While locked in S1, force L2D=001 (R2LandR2D=001) → next edge: fault=1, fault_code=2, locked=0. Code holds for 10 cycles; clr=1 → fault_code=0, locked=0.
- Hold the S1 pattern for 9 cycles while locked → fault_code=5 on the 9th sample, dwell=9.
- Go to S4 after 5 cycles of S3 → fault_code=4. Separately, jump S1→S3 → fault_code=3.
- Set L2R=011 while unlocked → fault_code=1. Then pulse rst mid-fault together with clr → all outputs at reset values on the next edge.
- Apply an S1 pattern that also carries D2R=010 → fault_code=2, not 3: conflict takes priority.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types, lamp codes, default timing and helpers for the traffic
// light monitor.
package tlc_pkg;

    // Lamp codes as driven on each 3-bit approach bus
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    // Default controller terminal counts (dwell = count + 1)
    localparam int TY_DEF  = 7;
    localparam int TR_DEF  = 2;
    localparam int TYY_DEF = 5;
    localparam int TRR_DEF = 3;

    typedef enum logic [2:0] {
        S1      = 3'd0,
        S2      = 3'd1,
        S3      = 3'd2,
        S4      = 3'd3,
        S5      = 3'd4,
        S6      = 3'd5,
        PH_NONE = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ENCODING = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_SEQUENCE = 3'd3,
        FC_SHORT    = 3'd4,
        FC_OVERSTAY = 3'd5
    } fault_code_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // True when a lamp bus carries exactly one of the three legal codes
    function automatic logic lamp_legal(input logic [2:0] code);
        return (code == GREEN) || (code == YELLOW) || (code == RED);
    endfunction

    // Controller phase order; S6 wraps back to S1
    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            S1:      return S2;
            S2:      return S3;
            S3:      return S4;
            S4:      return S5;
            S5:      return S6;
            S6:      return S1;
            default: return PH_NONE;
        endcase
    endfunction

    // Number of cycles the controller holds each phase
    function automatic logic [3:0] expected_dwell(input phase_t ph, input int ty,
                                                  input int tr, input int tyy,
                                                  input int trr);
        case (ph)
            S1, S5:  return 4'(ty + 1);
            S2, S6:  return 4'(tr + 1);
            S3:      return 4'(tyy + 1);
            S4:      return 4'(trr + 1);
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/tlc_light_monitor_if.sv
// Lamp buses from the controller plus the monitor's status outputs.
interface tlc_light_monitor_if;

    logic [2:0] L2R;
    logic [2:0] D2R;
    logic [2:0] L2D;
    logic [2:0] R2LandR2D;
    logic       clr;

    logic [2:0] phase;
    logic [3:0] dwell;
    logic       locked;
    logic       fault;
    logic [2:0] fault_code;
    logic       cycle_done;

    // Controller / host side: drives lamps and clr, observes status
    modport master (
        output L2R, D2R, L2D, R2LandR2D, clr,
        input  phase, dwell, locked, fault, fault_code, cycle_done
    );

    // Monitor side
    modport slave (
        input  L2R, D2R, L2D, R2LandR2D, clr,
        output phase, dwell, locked, fault, fault_code, cycle_done
    );

endinterface

// File: rtl/tlc_pattern_decode.sv
// Combinational decode of the four lamp buses into a phase index plus
// encoding-error and conflicting-green flags.
module tlc_pattern_decode
    import tlc_pkg::*;
(
    input  logic [2:0] l2r,
    input  logic [2:0] r2l_r2d,
    input  logic [2:0] l2d,
    input  logic [2:0] d2r,
    output phase_t     phase,
    output logic       enc_err,
    output logic       conflict
);

    // Map the lamp pattern (L2R, R2LandR2D, L2D, D2R) to a phase index
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        phase = PH_NONE;
        case ({l2r, r2l_r2d, l2d, d2r})
            {GREEN,  GREEN,  RED,    RED   }: phase = S1;
            {GREEN,  YELLOW, RED,    RED   }: phase = S2;
            {GREEN,  RED,    GREEN,  RED   }: phase = S3;
            {YELLOW, RED,    YELLOW, RED   }: phase = S4;
            {RED,    RED,    RED,    GREEN }: phase = S5;
            {RED,    RED,    RED,    YELLOW}: phase = S6;
            default:                          phase = PH_NONE;
        endcase
    end

    // Flag illegal lamp codes and crossing traffic released together
    always_comb begin
        enc_err  = !lamp_legal(l2r) || !lamp_legal(r2l_r2d) ||
                   !lamp_legal(l2d) || !lamp_legal(d2r);
        conflict = ((r2l_r2d != RED) && (l2d != RED)) ||
                   ((d2r != RED) &&
                    ((l2r != RED) || (r2l_r2d != RED) || (l2d != RED)));
    end

endmodule

// File: rtl/tlc_light_monitor.sv
// Safety monitor for the four-approach traffic light controller: decodes
// the lamp buses each cycle, checks phase order and dwell length, and
// latches a sticky fault code on the first unsafe or out-of-spec sample.
module tlc_light_monitor
    import tlc_pkg::*;
#(
    parameter int TY  = TY_DEF,
    parameter int TR  = TR_DEF,
    parameter int TYY = TYY_DEF,
    parameter int TRR = TRR_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    tlc_light_monitor_if.slave   bus
);

    phase_t      dec_phase;
    logic        enc_err;
    logic        conflict;

    state_t      state_q, state_d;
    phase_t      phase_q;
    logic [3:0]  dwell_q, dwell_d;
    fault_code_t code_q, code_d;
    fault_code_t hard_code;
    logic        done_q, done_d;

    tlc_pattern_decode u_decode (
        .l2r      (bus.L2R),
        .r2l_r2d  (bus.R2LandR2D),
        .l2d      (bus.L2D),
        .d2r      (bus.D2R),
        .phase    (dec_phase),
        .enc_err  (enc_err),
        .conflict (conflict)
    );

    // Lamp-level faults checked in every state; conflict outranks encoding
    always_comb begin
        hard_code = FC_NONE;
        if (conflict)     hard_code = FC_CONFLICT;
        else if (enc_err) hard_code = FC_ENCODING;
    end

    // Dwell counter: restarts at 1 on any phase change, saturates at 15
    always_comb begin
        if (dec_phase != phase_q) dwell_d = 4'd1;
        else if (dwell_q == 4'd15) dwell_d = 4'd15;
        else                       dwell_d = dwell_q + 4'd1;
    end

    // Next-state, fault latch and cycle-complete pulse
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        done_d  = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (hard_code != FC_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = hard_code;
                end else if (phase_q != PH_NONE && dec_phase != PH_NONE &&
                             dec_phase != phase_q) begin
                    // First legal-to-legal edge: dwell before it is unknown
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (hard_code != FC_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = hard_code;
                end else if (dec_phase == PH_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = FC_SEQUENCE;
                end else if (dec_phase == phase_q) begin
                    if (dwell_d > expected_dwell(dec_phase, TY, TR, TYY, TRR)) begin
                        state_d = ST_FAULT;
                        code_d  = FC_OVERSTAY;
                    end
                end else if (dec_phase == next_phase(phase_q)) begin
                    if (dwell_q != expected_dwell(phase_q, TY, TR, TYY, TRR)) begin
                        state_d = ST_FAULT;
                        code_d  = FC_SHORT;
                    end else if (phase_q == S6) begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_FAULT;
                    code_d  = FC_SEQUENCE;
                end
            end
            ST_FAULT: begin
                // A fault present in the clearing sample is latched afresh
                if (bus.clr) begin
                    if (hard_code != FC_NONE) begin
                        code_d = hard_code;
                    end else begin
                        state_d = ST_UNLOCKED;
                        code_d  = FC_NONE;
                    end
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                code_d  = FC_NONE;
            end
        endcase
    end

    // State, tracking and status registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_UNLOCKED;
            phase_q <= PH_NONE;
            dwell_q <= 4'd0;
            code_q  <= FC_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= dec_phase;
            dwell_q <= dwell_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.dwell      = dwell_q;
    assign bus.locked     = (state_q == ST_TRACK);
    assign bus.fault      = (state_q == ST_FAULT);
    assign bus.fault_code = code_q;
    assign bus.cycle_done = done_q;

endmodule
